// File: rtl/instruction_memory_responder.sv
// Memory-side responder for instruction-cache line refills: returns a 16-word line after a
// fixed latency from a side-loaded word array. Define IMEM_RESPONDER_STATS_EN for counters.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module instruction_memory_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_read,
  input  logic [`INSTRUCTION_WIDTH-1:0] mem_addr,
  output logic [511:0]                  mem_data,
  output logic                          mem_valid,
  output logic                          mem_err,
  output logic                          busy,
  input  logic                          load_en,
  input  logic [`INSTRUCTION_WIDTH-1:0] load_addr,
  input  logic [31:0]                   load_data
`ifdef IMEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]                   stat_req_count,
  output logic [31:0]                   stat_err_count
`endif
);

  localparam int          AW       = `INSTRUCTION_WIDTH;
  localparam int          IW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH_WORDS);
  localparam logic [7:0]  CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [AW:0]    base_q, base_d;
  logic [511:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic [31:0]    mem_q [0:DEPTH_WORDS-1];

  logic [AW:0]    req_base;
  logic [AW:0]    rd_base;
  logic [AW:0]    rd_last;
  logic           rd_oob;
  logic [511:0]   line_s;
  logic           unused_addr_bits;

  // One extra address bit keeps base+15 from wrapping at the top of the space.
  assign req_base         = {3'b000, mem_addr[AW-1:6], 4'b0000};
  assign rd_base          = (state_q == S_IDLE) ? req_base : base_q;
  assign rd_last          = rd_base + (AW+1)'(15);
  assign rd_oob           = (rd_last >= DEPTH_L);
  assign unused_addr_bits = ^mem_addr[5:0];

  always_comb begin
    line_s = '0;
    if (!rd_oob) begin
      for (int i = 0; i < 16; i++) begin
        line_s[32*i +: 32] = mem_q[rd_base[IW-1:0] + IW'(i)];
      end
    end else begin
      line_s = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_read) begin
          base_d = req_base;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Line is captured on the edge entering RESP, then held until the next response.
    if (state_d == S_RESP) begin
      valid_d = 1'b1;
      err_d   = rd_oob;
      data_d  = line_s;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      base_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; a same-edge load lands after the line read.
  always_ff @(posedge clk) begin
    if (load_en && ({1'b0, load_addr} < DEPTH_L)) begin
      mem_q[load_addr[IW-1:0]] <= load_data;
    end
  end

  assign mem_data  = data_q;
  assign mem_valid = valid_q;
  assign mem_err   = err_q;
  assign busy      = (state_q != S_IDLE);

`ifdef IMEM_RESPONDER_STATS_EN
  logic [31:0] req_cnt_q;
  logic [31:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_cnt_q <= 32'd0;
      err_cnt_q <= 32'd0;
    end else begin
      if ((state_q == S_IDLE) && mem_read && (req_cnt_q != 32'hFFFF_FFFF)) begin
        req_cnt_q <= req_cnt_q + 32'd1;
      end
      if ((state_d == S_RESP) && rd_oob && (err_cnt_q != 32'hFFFF_FFFF)) begin
        err_cnt_q <= err_cnt_q + 32'd1;
      end
    end
  end

  assign stat_req_count = req_cnt_q;
  assign stat_err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Scoreboard bench for instruction_memory_responder: expected lines are queued at request
// time and compared when mem_valid pulses; a second instance covers LATENCY=1.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module tb_instruction_memory_responder;
  localparam int AW = `INSTRUCTION_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_read1, load_en;
  logic [AW-1:0] mem_addr, mem_addr1, load_addr;
  logic [31:0]   load_data;
  logic [511:0]  mem_data, mem_data1;
  logic          mem_valid, mem_err, busy;
  logic          mem_valid1, mem_err1, busy1;
`ifdef IMEM_RESPONDER_STATS_EN
  logic [31:0]   sreq, serr, sreq1, serr1;
`endif

  int            total = 0;
  int            bad   = 0;
  logic [511:0]  exp_data_q [$];
  logic          exp_err_q  [$];
  logic [31:0]   shadow [0:4095];

  always #5 clk = ~clk;

  instruction_memory_responder #(.DEPTH_WORDS(4096), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_valid(mem_valid), .mem_err(mem_err), .busy(busy),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
`ifdef IMEM_RESPONDER_STATS_EN
    , .stat_req_count(sreq), .stat_err_count(serr)
`endif
  );

  instruction_memory_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(mem_read1), .mem_addr(mem_addr1),
    .mem_data(mem_data1), .mem_valid(mem_valid1), .mem_err(mem_err1), .busy(busy1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
`ifdef IMEM_RESPONDER_STATS_EN
    , .stat_req_count(sreq1), .stat_err_count(serr1)
`endif
  );

  task automatic check_val(input string tag, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input int base);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = shadow[base+i];
    return l;
  endfunction

  task automatic push_exp(input logic [511:0] d, input logic e);
    exp_data_q.push_back(d);
    exp_err_q.push_back(e);
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    if (a < 4096) shadow[a] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Leaves the bench at the first negedge after the accepting edge.
  task automatic accept(input logic [AW-1:0] addr);
    mem_addr = addr;
    mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    check_val("busy_after_accept", busy, 1);
  endtask

  task automatic wait_valid(input int start, input int want);
    int n;
    n = start;
    while (mem_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("latency", n, want);
    @(negedge clk);
    check_val("busy_after_resp", busy, 0);
  endtask

  // Scoreboard: every mem_valid pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (mem_valid === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        check_val("unexpected_valid", mem_valid, 0);
      end else begin
        check_val("line_data", mem_data, exp_data_q.pop_front());
        check_val("line_err", mem_err, exp_err_q.pop_front());
      end
    end else begin
      check_val("err_without_valid", mem_err, 0);
    end
  end

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_read1 = 1'b0; mem_addr = '0; mem_addr1 = '0;
    load_en = 1'b0; load_addr = '0; load_data = 32'd0;
    for (int i = 0; i < 4096; i++) shadow[i] = 32'd0;
    repeat (2) @(negedge clk);
    check_val("rst_valid", mem_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_data", mem_data, 0);
    check_val("rst_busy1", busy1, 0);
    rst = 1'b0;

    for (int i = 0; i < 48; i++) load_word(i, 32'h1000 + i);
    load_word(4096, 32'hBAD0_BAD0);

    // LATENCY=1 instance; offset bits of the address are ignored
    mem_addr1 = AW'(32'h47);
    mem_read1 = 1'b1;
    @(negedge clk);
    mem_read1 = 1'b0;
    check_val("l1_valid", mem_valid1, 1);
    check_val("l1_data", mem_data1, mk_line(16));
    check_val("l1_err", mem_err1, 0);
    check_val("l1_busy", busy1, 1);
    @(negedge clk);
    check_val("l1_valid_drop", mem_valid1, 0);
    check_val("l1_busy_drop", busy1, 0);

    // basic line 0 with held data afterwards
    push_exp(mk_line(0), 1'b0);
    accept(AW'(32'h0));
    wait_valid(1, 4);
    check_val("hold_w0", mem_data[31:0], 32'h1000);
    check_val("hold_w15", mem_data[511:480], 32'h100F);

    // first out-of-range line
    push_exp('0, 1'b1);
    accept(AW'(32'h4000));
    wait_valid(1, 4);
`ifdef IMEM_RESPONDER_STATS_EN
    check_val("stat_err", serr, 1);
    check_val("stat_req", sreq, 2);
`endif

    // top of address space must not wrap
    push_exp('0, 1'b1);
    accept(AW'(32'hFFFF_FFC0));
    wait_valid(1, 4);

    // mem_read held through WAIT with changing address
    mem_addr = AW'(32'h40);
    mem_read = 1'b1;
    push_exp(mk_line(16), 1'b0);
    @(negedge clk); check_val("hold_busy", busy, 1); mem_addr = AW'(32'h80);
    @(negedge clk); mem_addr = AW'(32'hC0);
    @(negedge clk); mem_addr = AW'(32'h80);
    @(negedge clk); check_val("hold_valid", mem_valid, 1); push_exp(mk_line(32), 1'b0);
    @(negedge clk); check_val("hold_idle", busy, 0);
    @(negedge clk); mem_read = 1'b0; check_val("second_busy", busy, 1);
    wait_valid(1, 4);

    // load during WAIT is visible
    shadow[5] = 32'hDEAD_BEEF;
    push_exp(mk_line(0), 1'b0);
    accept(AW'(32'h0));
    load_word(5, 32'hDEAD_BEEF);
    wait_valid(2, 4);

    // load on the RESP-entry edge is not visible, but is on the next request
    push_exp(mk_line(0), 1'b0);
    accept(AW'(32'h0));
    @(negedge clk);
    @(negedge clk);
    load_word(6, 32'hCAFE_F00D);
    wait_valid(4, 4);
    push_exp(mk_line(0), 1'b0);
    accept(AW'(32'h0));
    wait_valid(1, 4);

    // reset mid-transaction drops the request
    mem_addr = AW'(32'h0);
    mem_read = 1'b1;
    @(negedge clk); mem_read = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_val("rst_mid_busy", busy, 0);
    check_val("rst_mid_valid", mem_valid, 0);
    repeat (6) @(negedge clk);
    push_exp(mk_line(0), 1'b0);
    accept(AW'(32'h0));
    wait_valid(1, 4);
`ifdef IMEM_RESPONDER_STATS_EN
    check_val("stat_req_after_rst", sreq, 1);
    check_val("stat_err_after_rst", serr, 0);
`endif

    repeat (3) @(negedge clk);
    check_val("queue_drained", exp_data_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
